// File: rtl/dmem_ctrl_if.sv
// rtl/dmem_ctrl_if.sv - request/response bus between the load/store stage and dmem_ctrl
interface dmem_ctrl_if #(
  parameter int DEPTH = 4096,
  parameter int XLEN  = 32
);
  localparam int AW = $clog2(DEPTH) + $clog2(XLEN / 8);

  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [AW-1:0]   req_addr;
  logic [1:0]      req_size;
  logic            req_unsigned;
  logic [XLEN-1:0] req_wdata;
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - byte-addressed data-memory controller over a byte-writable single-port BRAM
// Loads/stores of 1..NB bytes at any offset; word-crossing accesses take a
// second BRAM cycle (SECOND) or are rejected when misalignment is disabled.
module dmem_ctrl #(
  parameter int DEPTH            = 4096,
  parameter int XLEN             = 32,
  parameter int ALLOW_MISALIGNED = 1
) (
  input  logic       clk,
  input  logic       rst,
  dmem_ctrl_if.slave bus
);
  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int WIDX = $clog2(DEPTH);
  localparam int AW   = WIDX + OFFW;
  localparam int MW   = 2 * NB;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_SECOND = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // request decode
  logic [OFFW-1:0]   w_off;
  logic [WIDX-1:0]   w_widx;
  logic [WIDX-1:0]   w_widx_nxt;
  logic [3:0]        w_n;
  logic              w_illegal;
  logic              w_cross;
  logic              w_err;
  logic              w_split;
  logic [MW-1:0]     w_mask2;
  logic [2*XLEN-1:0] w_dbl;
  logic [XLEN-1:0]   w_rot;

  // BRAM port
  logic              w_ready;
  logic              w_accept;
  logic              w_mem_en;
  logic [NB-1:0]     w_mem_we;
  logic [WIDX-1:0]   w_mem_addr;
  logic [XLEN-1:0]   w_mem_wdata;
  logic [XLEN-1:0]   r_mem [DEPTH];
  logic [XLEN-1:0]   r_rdata;

  // command captured at acceptance
  logic              r_we;
  logic              r_unsigned;
  logic              r_split;
  logic [OFFW-1:0]   r_off;
  logic [1:0]        r_size;
  logic [WIDX-1:0]   r_widx_nxt;
  logic [XLEN-1:0]   r_wdata_rot;
  logic [NB-1:0]     r_mask_hi;
  logic [XLEN-1:0]   r_lo;
  logic              r_rsp_valid;
  logic              r_rsp_err;

  // response assembly
  logic [2*XLEN-1:0] w_pair;
  logic [2*XLEN-1:0] w_pair_sh;
  logic [XLEN-1:0]   w_al;
  logic [XLEN-1:0]   w_keep;
  logic [XLEN-1:0]   w_msb;
  logic [XLEN-1:0]   w_ext;
  logic [XLEN-1:0]   w_rsp_rdata;
  int                w_bits;

  // Decode offset/size, crossing and error, lane mask over two words and rotated store data
  always_comb begin
    w_off      = bus.req_addr[OFFW-1:0];
    w_widx     = bus.req_addr[AW-1:OFFW];
    w_n        = 4'd1 << bus.req_size;
    w_illegal  = int'(w_n) > NB;
    w_cross    = (int'(w_off) + int'(w_n)) > NB;
    w_err      = w_illegal || (w_cross && (ALLOW_MISALIGNED == 0));
    w_split    = w_cross && !w_illegal && (ALLOW_MISALIGNED != 0);
    // Low NB bits cover word w, high NB bits the spill into word w+1
    w_mask2    = ((MW'(1) << w_n) - MW'(1)) << w_off;
    w_dbl      = {bus.req_wdata, bus.req_wdata} << {w_off, 3'b000};
    w_rot      = w_dbl[2*XLEN-1:XLEN];
    w_widx_nxt = (w_widx == WIDX'(DEPTH - 1)) ? '0 : w_widx + WIDX'(1);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, handshake and BRAM port control
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_accept    = 1'b0;
    w_mem_en    = 1'b0;
    w_mem_we    = '0;
    w_mem_addr  = w_widx;
    w_mem_wdata = w_rot;
    case (r_state)
      S_IDLE: begin
        w_ready  = 1'b1;
        w_accept = bus.req_valid;
        if (w_accept && !w_err) begin
          w_mem_en = 1'b1;
          w_mem_we = bus.req_we ? w_mask2[NB-1:0] : '0;
          if (w_split) begin
            w_state_nxt = S_SECOND;
          end
        end
      end
      S_SECOND: begin
        w_state_nxt = S_IDLE;
        w_mem_en    = 1'b1;
        w_mem_addr  = r_widx_nxt;
        w_mem_wdata = r_wdata_rot;
        w_mem_we    = r_we ? r_mask_hi : '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    // Reset aborts any access in flight, including a pending second-half write
    if (rst) begin
      w_mem_en = 1'b0;
      w_mem_we = '0;
    end
  end

  // Byte-writable BRAM with registered read; contents survive reset
  always_ff @(posedge clk) begin
    if (w_mem_en) begin
      for (int b = 0; b < NB; b++) begin
        if (w_mem_we[b]) begin
          r_mem[w_mem_addr][8*b +: 8] <= w_mem_wdata[8*b +: 8];
        end
      end
      r_rdata <= r_mem[w_mem_addr];
    end
  end

  // Capture command at acceptance, keep first-word data for crossing loads, time the response
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_we        <= 1'b0;
      r_unsigned  <= 1'b0;
      r_split     <= 1'b0;
      r_off       <= '0;
      r_size      <= '0;
      r_widx_nxt  <= '0;
      r_wdata_rot <= '0;
      r_mask_hi   <= '0;
      r_lo        <= '0;
    end else begin
      r_rsp_valid <= (w_accept && !w_split) || (r_state == S_SECOND);
      r_rsp_err   <= w_accept && w_err;
      if (w_accept) begin
        r_we        <= bus.req_we;
        r_unsigned  <= bus.req_unsigned;
        r_split     <= w_split;
        r_off       <= w_off;
        r_size      <= bus.req_size;
        r_widx_nxt  <= w_widx_nxt;
        r_wdata_rot <= w_rot;
        r_mask_hi   <= w_mask2[MW-1:NB];
      end
      if (r_state == S_SECOND) begin
        r_lo <= r_rdata;
      end
    end
  end

  // Right-align the addressed bytes and extend above 8n bits
  always_comb begin
    w_pair    = r_split ? {r_rdata, r_lo} : {r_rdata, r_rdata};
    w_pair_sh = w_pair >> {r_off, 3'b000};
    w_al      = w_pair_sh[XLEN-1:0];
    w_bits    = 8 << r_size;
    w_keep    = '1;
    w_msb     = '0;
    w_ext     = w_al;
    if (w_bits < XLEN) begin
      w_keep = (XLEN'(1) << w_bits) - XLEN'(1);
      w_msb  = XLEN'(1) << (w_bits - 1);
      w_ext  = w_al & w_keep;
      if (!r_unsigned && ((w_al & w_msb) != '0)) begin
        w_ext = w_ext | ~w_keep;
      end
    end
    w_rsp_rdata = (r_rsp_valid && !r_rsp_err && !r_we) ? w_ext : '0;
  end

  assign bus.req_ready = w_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.rsp_rdata = w_rsp_rdata;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - self-checking bench for dmem_ctrl against a byte-array reference model
module tb_dmem_ctrl;
  localparam int DEPTH  = 256;
  localparam int XLEN   = 32;
  localparam int NBYTES = DEPTH * 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_ctrl_if #(.DEPTH(DEPTH), .XLEN(XLEN)) ifa();
  dmem_ctrl_if #(.DEPTH(DEPTH), .XLEN(XLEN)) ifb();

  dmem_ctrl #(.DEPTH(DEPTH), .XLEN(XLEN), .ALLOW_MISALIGNED(1)) u_dut_a (.clk(clk), .rst(rst), .bus(ifa));
  dmem_ctrl #(.DEPTH(DEPTH), .XLEN(XLEN), .ALLOW_MISALIGNED(0)) u_dut_b (.clk(clk), .rst(rst), .bus(ifb));

  int checks = 0;
  int failures = 0;
  logic [7:0] mem_m [2][NBYTES];

  function automatic bit m_cross(int addr, int size);
    return ((addr % 4) + (1 << size)) > 4;
  endfunction

  function automatic bit m_err(int which, int addr, int size);
    return (size == 3) || (which == 1 && m_cross(addr, size));
  endfunction

  function automatic int m_lat(int which, int addr, int size);
    if (m_err(which, addr, size)) return 1;
    return m_cross(addr, size) ? 2 : 1;
  endfunction

  function automatic logic [31:0] m_load(int which, int addr, int size, bit uns);
    logic [31:0] v;
    int n;
    v = '0;
    if (m_err(which, addr, size)) return v;
    n = 1 << size;
    for (int i = 0; i < n; i++) v = v | (32'(mem_m[which][(addr + i) % NBYTES]) << (8 * i));
    if (n < 4 && !uns && v[8*n-1]) v = v | ~((32'(1) << (8 * n)) - 32'(1));
    return v;
  endfunction

  task automatic m_store(int which, int addr, int size, logic [31:0] data);
    for (int i = 0; i < (1 << size); i++) mem_m[which][(addr + i) % NBYTES] = data[8*i +: 8];
  endtask

  task automatic drive(int which, bit valid, bit we, int addr, int size, bit uns, logic [31:0] wdata);
    if (which == 0) begin
      ifa.req_valid = valid; ifa.req_we = we; ifa.req_addr = 10'(addr);
      ifa.req_size = 2'(size); ifa.req_unsigned = uns; ifa.req_wdata = wdata;
    end else begin
      ifb.req_valid = valid; ifb.req_we = we; ifb.req_addr = 10'(addr);
      ifb.req_size = 2'(size); ifb.req_unsigned = uns; ifb.req_wdata = wdata;
    end
  endtask

  task automatic do_req(input int which, input bit we, input int addr, input int size, input bit uns,
                        input logic [31:0] wdata, output logic [31:0] rdata, output bit err,
                        output int lat, output bit dip, output bit got);
    bit rdy;
    @(negedge clk);
    drive(which, 1'b1, we, addr, size, uns, wdata);
    @(posedge clk);
    #1;
    drive(which, 1'b0, 1'b0, 0, 0, 1'b0, 32'h0);
    if (we && !m_err(which, addr, size)) m_store(which, addr, size, wdata);
    rdata = '0; err = 1'b0; lat = 0; dip = 1'b0; got = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      rdy = (which == 0) ? ifa.req_ready : ifb.req_ready;
      if (!rdy) dip = 1'b1;
      if ((which == 0) ? ifa.rsp_valid : ifb.rsp_valid) begin
        got = 1'b1; lat = c;
        rdata = (which == 0) ? ifa.rsp_rdata : ifb.rsp_rdata;
        err = (which == 0) ? ifa.rsp_err : ifb.rsp_err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (ifa.rsp_valid !== 1'b0 || ifa.rsp_err !== 1'b0 || ifa.rsp_rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs_a got valid=%b err=%b rdata=%h want 0 0 0", ifa.rsp_valid, ifa.rsp_err, ifa.rsp_rdata);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ifa.req_ready !== 1'b1 || ifb.req_ready !== 1'b1 || ifb.rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready got a=%b b=%b bvalid=%b want 1 1 0", ifa.req_ready, ifb.req_ready, ifb.rsp_valid);
    end
  endtask

  task automatic test_init();
    logic [31:0] rd; bit err, dip, got; int lat, w;
    for (int k = 0; k < 68; k++) begin
      w = (k % 34 < 32) ? (k % 34) : (k % 34) + 222;
      do_req(k / 34, 1'b1, w * 4, 2, 1'b0, $urandom, rd, err, lat, dip, got);
      checks++;
      if (!got || err !== 1'b0 || rd !== 32'h0 || lat != 1) begin
        failures++;
        $display("FAIL init_store word=%0d got=%b err=%b rdata=%h lat=%0d want 1 0 0 1", w, got, err, rd, lat);
      end
    end
  endtask

  task automatic test_aligned();
    logic [31:0] rd; bit err, dip, got; int lat;
    do_req(0, 1'b1, 32'h10, 2, 1'b0, 32'hDEADBEEF, rd, err, lat, dip, got);
    checks++;
    if (!got || lat != 1 || err !== 1'b0 || rd !== 32'h0 || dip) begin
      failures++;
      $display("FAIL aligned_sw got=%b lat=%0d err=%b rdata=%h dip=%b want 1 1 0 0 0", got, lat, err, rd, dip);
    end
    do_req(0, 1'b0, 32'h10, 2, 1'b0, 32'h0, rd, err, lat, dip, got);
    checks++;
    if (!got || lat != 1 || err !== 1'b0 || rd !== 32'hDEADBEEF || dip) begin
      failures++;
      $display("FAIL aligned_lw got=%b lat=%0d err=%b rdata=%h dip=%b want 1 1 0 deadbeef 0", got, lat, err, rd, dip);
    end
  endtask

  task automatic test_byte_half();
    logic [31:0] rd; bit err, dip, got; int lat;
    int          t_addr [5] = '{32'h21, 32'h22, 32'h23, 32'h22, 32'h21};
    int          t_size [5] = '{0, 0, 0, 1, 1};
    bit          t_uns  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] t_exp  [5] = '{32'h0000007F, 32'hFFFFFFFF, 32'h00000080, 32'hFFFF80FF, 32'h0000FF7F};
    do_req(0, 1'b1, 32'h20, 2, 1'b0, 32'h80FF7F01, rd, err, lat, dip, got);
    for (int i = 0; i < 5; i++) begin
      do_req(0, 1'b0, t_addr[i], t_size[i], t_uns[i], 32'h0, rd, err, lat, dip, got);
      checks++;
      if (!got || lat != 1 || err !== 1'b0 || rd !== t_exp[i] || dip) begin
        failures++;
        $display("FAIL byte_half_%0d got=%b lat=%0d err=%b rdata=%h want rdata=%h lat=1", i, got, lat, err, rd, t_exp[i]);
      end
    end
  endtask

  task automatic test_cross();
    logic [31:0] rd; bit err, dip, got; int lat;
    do_req(0, 1'b1, 32'h30, 2, 1'b0, 32'h44332211, rd, err, lat, dip, got);
    do_req(0, 1'b1, 32'h34, 2, 1'b0, 32'h88776655, rd, err, lat, dip, got);
    do_req(0, 1'b0, 32'h33, 2, 1'b0, 32'h0, rd, err, lat, dip, got);
    checks++;
    if (!got || lat != 2 || !dip || err !== 1'b0 || rd !== 32'h77665544) begin
      failures++;
      $display("FAIL cross_lw got=%b lat=%0d dip=%b err=%b rdata=%h want 1 2 1 0 77665544", got, lat, dip, err, rd);
    end
    do_req(0, 1'b1, 32'h32, 2, 1'b0, 32'hAABBCCDD, rd, err, lat, dip, got);
    checks++;
    if (!got || lat != 2 || !dip || err !== 1'b0 || rd !== 32'h0) begin
      failures++;
      $display("FAIL cross_sw got=%b lat=%0d dip=%b err=%b rdata=%h want 1 2 1 0 0", got, lat, dip, err, rd);
    end
    do_req(0, 1'b0, 32'h30, 2, 1'b0, 32'h0, rd, err, lat, dip, got);
    checks++;
    if (rd !== 32'hCCDD2211) begin
      failures++;
      $display("FAIL cross_word30 got=%h want ccdd2211", rd);
    end
    do_req(0, 1'b0, 32'h34, 2, 1'b0, 32'h0, rd, err, lat, dip, got);
    checks++;
    if (rd !== 32'h8877AABB) begin
      failures++;
      $display("FAIL cross_word34 got=%h want 8877aabb", rd);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] rd; bit err, dip, got; int lat;
    do_req(0, 1'b1, NBYTES - 1, 1, 1'b0, 32'h0000BEEF, rd, err, lat, dip, got);
    checks++;
    if (!got || lat != 2 || err !== 1'b0) begin
      failures++;
      $display("FAIL wrap_sh got=%b lat=%0d err=%b want 1 2 0", got, lat, err);
    end
    do_req(0, 1'b0, NBYTES - 4, 2, 1'b0, 32'h0, rd, err, lat, dip, got);
    checks++;
    if (rd[31:24] !== 8'hEF || rd !== m_load(0, NBYTES - 4, 2, 1'b0)) begin
      failures++;
      $display("FAIL wrap_last_word got=%h want byte3=ef word=%h", rd, m_load(0, NBYTES - 4, 2, 1'b0));
    end
    do_req(0, 1'b0, 0, 2, 1'b0, 32'h0, rd, err, lat, dip, got);
    checks++;
    if (rd[7:0] !== 8'hBE || rd !== m_load(0, 0, 2, 1'b0)) begin
      failures++;
      $display("FAIL wrap_word0 got=%h want byte0=be word=%h", rd, m_load(0, 0, 2, 1'b0));
    end
  endtask

  task automatic test_illegal_size();
    logic [31:0] rd; bit err, dip, got; int lat;
    do_req(0, 1'b1, 32'h40, 3, 1'b0, 32'h12345678, rd, err, lat, dip, got);
    checks++;
    if (!got || lat != 1 || err !== 1'b1 || rd !== 32'h0) begin
      failures++;
      $display("FAIL illegal_size got=%b lat=%0d err=%b rdata=%h want 1 1 1 0", got, lat, err, rd);
    end
    do_req(0, 1'b0, 32'h40, 2, 1'b0, 32'h0, rd, err, lat, dip, got);
    checks++;
    if (rd !== m_load(0, 32'h40, 2, 1'b0)) begin
      failures++;
      $display("FAIL illegal_nowrite got=%h want %h", rd, m_load(0, 32'h40, 2, 1'b0));
    end
  endtask

  task automatic test_no_misalign();
    logic [31:0] rd; bit err, dip, got; int lat;
    do_req(1, 1'b0, 32'h31, 2, 1'b0, 32'h0, rd, err, lat, dip, got);
    checks++;
    if (!got || lat != 1 || err !== 1'b1 || rd !== 32'h0) begin
      failures++;
      $display("FAIL nomis_lw got=%b lat=%0d err=%b rdata=%h want 1 1 1 0", got, lat, err, rd);
    end
    do_req(1, 1'b1, 32'h31, 2, 1'b0, 32'hFEEDFACE, rd, err, lat, dip, got);
    checks++;
    if (!got || lat != 1 || err !== 1'b1) begin
      failures++;
      $display("FAIL nomis_sw got=%b lat=%0d err=%b want 1 1 1", got, lat, err);
    end
    do_req(1, 1'b0, 32'h30, 2, 1'b0, 32'h0, rd, err, lat, dip, got);
    checks++;
    if (rd !== m_load(1, 32'h30, 2, 1'b0)) begin
      failures++;
      $display("FAIL nomis_word30 got=%h want %h", rd, m_load(1, 32'h30, 2, 1'b0));
    end
    do_req(1, 1'b0, 32'h34, 2, 1'b0, 32'h0, rd, err, lat, dip, got);
    checks++;
    if (rd !== m_load(1, 32'h34, 2, 1'b0)) begin
      failures++;
      $display("FAIL nomis_word34 got=%h want %h", rd, m_load(1, 32'h34, 2, 1'b0));
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q [$];
    logic [31:0] e, wd;
    int a, s; bit we, uns;
    @(negedge clk);
    for (int i = 0; i <= 40; i++) begin
      if (i > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (ifa.rsp_valid !== 1'b1 || ifa.rsp_err !== 1'b0 || ifa.rsp_rdata !== e || ifa.req_ready !== 1'b1) begin
          failures++;
          $display("FAIL b2b_%0d valid=%b err=%b rdata=%h ready=%b want 1 0 %h 1", i, ifa.rsp_valid, ifa.rsp_err, ifa.rsp_rdata, ifa.req_ready, e);
        end
      end
      if (i < 40) begin
        s = $urandom_range(0, 2);
        a = ($urandom_range(0, 120) >> s) << s;
        we = 1'($urandom_range(0, 1));
        uns = 1'($urandom_range(0, 1));
        wd = $urandom;
        if (we) begin
          m_store(0, a, s, wd);
          exp_q.push_back(32'h0);
        end else begin
          exp_q.push_back(m_load(0, a, s, uns));
        end
        drive(0, 1'b1, we, a, s, uns, wd);
      end else begin
        drive(0, 1'b0, 1'b0, 0, 0, 1'b0, 32'h0);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; bit err, dip, got; int lat;
    do_req(0, 1'b1, 32'h30, 2, 1'b0, 32'h11223344, rd, err, lat, dip, got);
    do_req(0, 1'b1, 32'h34, 2, 1'b0, 32'h55667788, rd, err, lat, dip, got);
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 32'h33, 2, 1'b0, 32'hCAFEF00D);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 1'b0, 0, 0, 1'b0, 32'h0);
    @(negedge clk);
    checks++;
    if (ifa.req_ready !== 1'b0 || ifa.rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL rmid_second ready=%b valid=%b want 0 0", ifa.req_ready, ifa.rsp_valid);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (ifa.req_ready !== 1'b1 || ifa.rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL rmid_after ready=%b valid=%b want 1 0", ifa.req_ready, ifa.rsp_valid);
    end
    @(negedge clk);
    checks++;
    if (ifa.rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL rmid_norsp valid=%b want 0", ifa.rsp_valid);
    end
    mem_m[0][32'h33] = 8'h0D;
    do_req(0, 1'b0, 32'h30, 2, 1'b0, 32'h0, rd, err, lat, dip, got);
    checks++;
    if (rd !== 32'h0D223344) begin
      failures++;
      $display("FAIL rmid_word30 got=%h want 0d223344", rd);
    end
    do_req(0, 1'b0, 32'h34, 2, 1'b0, 32'h0, rd, err, lat, dip, got);
    checks++;
    if (rd !== 32'h55667788) begin
      failures++;
      $display("FAIL rmid_word34 got=%h want 55667788", rd);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, wd, e; bit err, dip, got, we, uns, ee; int lat, el, wh, a, s;
    for (int k = 0; k < 150; k++) begin
      wh = $urandom_range(0, 1);
      we = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      s = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
      a = ($urandom_range(0, 4) == 0) ? $urandom_range(NBYTES - 8, NBYTES - 1) : $urandom_range(0, 120);
      wd = $urandom;
      e = we ? 32'h0 : m_load(wh, a, s, uns);
      ee = m_err(wh, a, s);
      el = m_lat(wh, a, s);
      do_req(wh, we, a, s, uns, wd, rd, err, lat, dip, got);
      checks++;
      if (!got || rd !== e || err !== ee || lat != el) begin
        failures++;
        $display("FAIL rand_%0d dut=%0d we=%b addr=%h size=%0d got=%b rdata=%h err=%b lat=%0d want %h %b %0d",
                 k, wh, we, a, s, got, rd, err, lat, e, ee, el);
      end
    end
  endtask

  initial begin
    drive(0, 1'b0, 1'b0, 0, 0, 1'b0, 32'h0);
    drive(1, 1'b0, 1'b0, 0, 0, 1'b0, 32'h0);
    test_reset();
    test_init();
    test_aligned();
    test_byte_half();
    test_cross();
    test_wrap();
    test_illegal_size();
    test_no_misalign();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
